// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
//   Groups the lock/request inputs and sequenced reset outputs of reset_sequencer.
//   master : board/PLL side, drives iPLL_LOCKED and iSW_RST, observes the outputs.
//   slave  : the sequencer itself.
// Signals
//   iPLL_LOCKED  PLL lock, asynchronous to the sequencer clock
//   iSW_RST      synchronous restart request (level or pulse)
//   oRST_N       per-domain active-low resets, thermometer coded
//   oREADY       all domains released
//   oSTATE       0=WAIT_LOCK 1=DELAY 2=RUN
interface reset_sequencer_if #(
   parameter int unsigned NUM_STAGES = 3
) ();
   logic                  iPLL_LOCKED;
   logic                  iSW_RST;
   logic [NUM_STAGES-1:0] oRST_N;
   logic                  oREADY;
   logic [1:0]            oSTATE;

   modport master (
      output iPLL_LOCKED,
      output iSW_RST,
      input  oRST_N,
      input  oREADY,
      input  oSTATE
   );

   modport slave (
      input  iPLL_LOCKED,
      input  iSW_RST,
      output oRST_N,
      output oREADY,
      output oSTATE
   );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Multi-stage power-on/lock reset controller. Waits for a synchronised PLL lock,
//   then releases NUM_STAGES active-low domain resets in order, STAGE_DLY cycles
//   apart. Lock loss or a software request aborts and restarts the sequence.
// Ports
//   iCLK    system clock, all logic on posedge
//   iRST_N  asynchronous active-low reset
//   bus     reset_sequencer_if.slave (iPLL_LOCKED, iSW_RST, oRST_N, oREADY, oSTATE)
// Build option
//   RESET_SEQ_LOCK_FILTER_EN : require LOCK_FILT consecutive synced-lock-high cycles
//   before the sequence starts. Undefined: the synced lock starts it directly.
module reset_sequencer #(
   parameter int unsigned NUM_STAGES = 3,
   parameter int unsigned CNT_W      = 20,
   parameter int unsigned STAGE_DLY  = 20'hFFFFF
`ifdef RESET_SEQ_LOCK_FILTER_EN
   , parameter int unsigned LOCK_FILT = 16
`endif
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   reset_sequencer_if.slave   bus
);

   localparam int unsigned     StgW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [CNT_W-1:0] DlyLast = CNT_W'(STAGE_DLY - 1);
   localparam logic [StgW-1:0]  StgLast = StgW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      StWaitLock = 2'd0,
      StDelay    = 2'd1,
      StRun      = 2'd2
   } state_e;

   state_e                r_state;
   logic [1:0]            r_sync;
   logic [CNT_W-1:0]      r_cnt;
   logic [StgW-1:0]       r_stage;
   logic [NUM_STAGES-1:0] r_rst_n;
   logic                  r_ready;

   logic w_lk_s;
   logic w_abort;
   logic w_lock_ok;

   assign w_lk_s  = r_sync[1];
   assign w_abort = ~w_lk_s | bus.iSW_RST;

`ifdef RESET_SEQ_LOCK_FILTER_EN
   localparam int unsigned    FiltW   = $clog2(LOCK_FILT + 1);
   localparam logic [FiltW-1:0] FiltMax = FiltW'(LOCK_FILT);

   logic [FiltW-1:0] r_fcnt;

   // Saturating run-length of synced lock; abort (incl. lock loss) clears it.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_fcnt <= '0;
      end else if (w_abort) begin
         r_fcnt <= '0;
      end else if (r_fcnt != FiltMax) begin
         r_fcnt <= r_fcnt + 1'b1;
      end
   end

   assign w_lock_ok = (r_fcnt == FiltMax);
`else
   assign w_lock_ok = w_lk_s;
`endif

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_sync  <= '0;
         r_state <= StWaitLock;
         r_cnt   <= '0;
         r_stage <= '0;
         r_rst_n <= '0;
         r_ready <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], bus.iPLL_LOCKED};
         // Abort beats every state transition, including a final release on this edge.
         if (w_abort) begin
            r_state <= StWaitLock;
            r_cnt   <= '0;
            r_stage <= '0;
            r_rst_n <= '0;
            r_ready <= 1'b0;
         end else begin
            unique case (r_state)
               StWaitLock: begin
                  if (w_lock_ok) begin
                     r_state <= StDelay;
                     r_cnt   <= '0;
                  end
               end
               StDelay: begin
                  if (r_cnt == DlyLast) begin
                     r_cnt            <= '0;
                     r_rst_n[r_stage] <= 1'b1;
                     if (r_stage == StgLast) begin
                        r_state <= StRun;
                        r_ready <= 1'b1;
                     end else begin
                        r_stage <= r_stage + 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               StRun: begin
                  r_state <= StRun;
               end
               default: begin
                  r_state <= StWaitLock;
               end
            endcase
         end
      end
   end

   assign bus.oRST_N = r_rst_n;
   assign bus.oREADY = r_ready;
   assign bus.oSTATE = r_state;

endmodule
